// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - load/store unit in front of a big-endian byte-addressed 32-bit RAM
// Optional feature: define LSU_ALIGN_CHECK_EN to report misaligned half/word accesses as errors.

`ifndef RAM_READ
`define RAM_READ  2'd0
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 2'd1
`endif

module mem_lsu (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_signed,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_err,
    output logic [1:0]  o_ram_action,
    output logic [31:0] o_ram_addr,
    input  logic [31:0] i_ram_val,
    output logic [31:0] o_ram_val
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    // Only the bytes that survive a sub-word merge need to be kept.
    logic [23:0] buf_q, buf_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        err_q, err_d;

    logic        accept;
    logic        req_err;
    logic [31:0] merged;

    // Pick the leading byte/half of the fetched word and extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] w,
                                                input logic [1:0]  size,
                                                input logic        sgn);
        logic [31:0] r;
        case (size)
            SZ_BYTE: r = {{24{sgn & w[31]}}, w[31:24]};
            SZ_HALF: r = {{16{sgn & w[31]}}, w[31:16]};
            default: r = w;
        endcase
        return r;
    endfunction

    assign o_req_ready = (state_q == ST_IDLE) && !i_rst;
    assign accept      = i_req_valid && o_req_ready;

    // Classify the incoming request as not performable.
    always_comb begin
        req_err = (i_req_size == SZ_RSVD);
`ifdef LSU_ALIGN_CHECK_EN
        if ((i_req_size == SZ_HALF) && i_req_addr[0])
            req_err = 1'b1;
        if ((i_req_size == SZ_WORD) && (i_req_addr[1:0] != 2'b00))
            req_err = 1'b1;
`endif
    end

    // Build the write word: new data in the leading bytes, old trailing bytes kept.
    always_comb begin
        case (size_q)
            SZ_BYTE: merged = {wdata_q[7:0], buf_q};
            SZ_HALF: merged = {wdata_q[15:0], buf_q[15:0]};
            default: merged = wdata_q;
        endcase
    end

    // RAM port; reset gates the write strobe so an aborted store never commits.
    always_comb begin
        o_ram_action = ((state_q == ST_WRITE) && !i_rst) ? `RAM_WRITE : `RAM_READ;
        o_ram_addr   = ((state_q == ST_READ) || (state_q == ST_WRITE)) ? addr_q : 32'd0;
        o_ram_val    = (state_q == ST_WRITE) ? merged : 32'd0;
    end

    // Next-state and response logic; response registers are only nonzero while in RESP.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        signed_d    = signed_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'd0;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d     = i_req_we;
                    size_d   = i_req_size;
                    signed_d = i_req_signed;
                    addr_d   = i_req_addr;
                    wdata_d  = i_req_wdata;
                    if (req_err) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        err_d       = 1'b1;
                    end else if (i_req_we && (i_req_size == SZ_WORD)) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                buf_d = i_ram_val[23:0];
                if (we_q) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_extend(i_ram_val, size_q, signed_q);
                end
            end
            ST_WRITE: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            signed_q    <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            buf_q       <= 24'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_q       <= err_d;
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - self-checking bench for mem_lsu with a byte-array RAM and reference memory

`timescale 1ns/1ps

`ifndef RAM_READ
`define RAM_READ  2'd0
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 2'd1
`endif

module tb_mem_lsu;

    logic        i_clk;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [1:0]  i_req_size;
    logic        i_req_signed;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_err;
    logic [1:0]  o_ram_action;
    logic [31:0] o_ram_addr;
    logic [31:0] i_ram_val;
    logic [31:0] o_ram_val;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0]  ram     [256];
    logic [7:0]  ref_mem [256];
    int          wr_count;
    logic [31:0] last_wval;

    mem_lsu dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_we     (i_req_we),
        .i_req_size   (i_req_size),
        .i_req_signed (i_req_signed),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_err        (o_err),
        .o_ram_action (o_ram_action),
        .o_ram_addr   (o_ram_addr),
        .i_ram_val    (i_ram_val),
        .o_ram_val    (o_ram_val)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // RAM: combinational big-endian read, 8-bit address wrap inside the bench array.
    always_comb begin
        logic [7:0] a;
        a = o_ram_addr[7:0];
        i_ram_val = {ram[a], ram[8'(a + 8'd1)], ram[8'(a + 8'd2)], ram[8'(a + 8'd3)]};
    end

    // RAM commits the whole word on any edge that sees a write strobe.
    always @(posedge i_clk) begin
        if (o_ram_action == `RAM_WRITE) begin
            logic [7:0] a;
            a = o_ram_addr[7:0];
            ram[a]             = o_ram_val[31:24];
            ram[8'(a + 8'd1)]  = o_ram_val[23:16];
            ram[8'(a + 8'd2)]  = o_ram_val[15:8];
            ram[8'(a + 8'd3)]  = o_ram_val[7:0];
            wr_count           = wr_count + 1;
            last_wval          = o_ram_val;
        end
    end

    // Reference model of one request: expected result and effect on ref_mem.
    task automatic model_req(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] e_rdata, output logic e_err,
                             output int e_lat, output int e_wr);
        logic [7:0] a;
        int nbytes;
        logic [31:0] v;
        a = addr[7:0];
        e_err = (size == 2'd3);
`ifdef LSU_ALIGN_CHECK_EN
        if (size == 2'd1 && addr[0] != 1'b0) e_err = 1'b1;
        if (size == 2'd2 && addr[1:0] != 2'b00) e_err = 1'b1;
`endif
        e_rdata = 32'd0;
        e_wr    = 0;
        if (e_err) begin
            e_lat = 1;
        end else begin
            nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
            if (we) begin
                e_wr  = 1;
                e_lat = (nbytes == 4) ? 2 : 3;
                for (int i = 0; i < nbytes; i++)
                    ref_mem[8'(a + 8'(i))] = 8'(wdata >> (8 * (nbytes - 1 - i)));
            end else begin
                e_lat = 2;
                v = 32'd0;
                for (int i = 0; i < nbytes; i++)
                    v = (v << 8) | 32'(ref_mem[8'(a + 8'(i))]);
                if (sgn && nbytes < 4 && v[8 * nbytes - 1])
                    v = v | ~((32'd1 << (8 * nbytes)) - 32'd1);
                e_rdata = v;
            end
        end
    endtask

    // Issue one request and observe its response; lat is 0 if none arrived in time.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output logic pulse_ok);
        int w;
        @(negedge i_clk);
        w = 0;
        while (!o_req_ready && w < 20) begin
            @(negedge i_clk);
            w++;
        end
        wr_count     = 0;
        i_req_valid  = 1'b1;
        i_req_we     = we;
        i_req_size   = size;
        i_req_signed = sgn;
        i_req_addr   = addr;
        i_req_wdata  = wdata;
        @(posedge i_clk);
        #1;
        i_req_valid  = 1'b0;
        lat      = 0;
        rdata    = 32'd0;
        err      = 1'b0;
        pulse_ok = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge i_clk);
            if (o_rsp_valid) begin
                lat   = n;
                rdata = o_rsp_rdata;
                err   = o_err;
                break;
            end
        end
        if (lat != 0) begin
            @(negedge i_clk);
            pulse_ok = !o_rsp_valid && (o_rsp_rdata == 32'd0) && !o_err;
        end
    endtask

    task automatic test_reset;
        #2;
        tests_run++;
        if ({o_req_ready, o_rsp_valid, o_err} !== 3'b000 || o_rsp_rdata !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_rsp: ready/valid/err=%b rdata=%h required 000 / 00000000",
                     {o_req_ready, o_rsp_valid, o_err}, o_rsp_rdata);
        end
        tests_run++;
        if (o_ram_action !== `RAM_READ || o_ram_addr !== 32'd0 || o_ram_val !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_ram: action=%0d addr=%h val=%h required RAM_READ/0/0",
                     o_ram_action, o_ram_addr, o_ram_val);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        tests_run++;
        if (o_req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b required 1", o_req_ready);
        end
    endtask

    // Directed load table against the preloaded bytes 80 12 34 56 at 0x10.
    task automatic test_loads;
        logic [1:0]  t_size [4] = '{2'd2, 2'd0, 2'd0, 2'd1};
        logic        t_sgn  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] t_addr [4] = '{32'h10, 32'h10, 32'h10, 32'h12};
        logic [31:0] t_exp  [4] = '{32'h80123456, 32'hFFFFFF80, 32'h00000080, 32'h00003456};
        logic [31:0] rd;
        logic        er, pok;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, t_size[i], t_sgn[i], t_addr[i], 32'h0, rd, er, lat, pok);
            tests_run++;
            if (rd !== t_exp[i] || er !== 1'b0 || lat != 2 || wr_count != 0 || !pok) begin
                tests_failed++;
                $display("FAIL load_%0d: rdata=%h err=%b lat=%0d writes=%0d pulse=%b required %h 0 2 0 1",
                         i, rd, er, lat, wr_count, pok, t_exp[i]);
            end
        end
    endtask

    task automatic test_misaligned_half;
        logic [31:0] rd;
        logic        er, pok;
        int          lat;
        logic [31:0] x_rd;
        logic        x_er;
        int          x_lat;
`ifdef LSU_ALIGN_CHECK_EN
        x_rd = 32'h0; x_er = 1'b1; x_lat = 1;
`else
        x_rd = 32'h00001234; x_er = 1'b0; x_lat = 2;
`endif
        do_req(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, rd, er, lat, pok);
        tests_run++;
        if (rd !== x_rd || er !== x_er || lat != x_lat || wr_count != 0) begin
            tests_failed++;
            $display("FAIL misaligned_half: rdata=%h err=%b lat=%0d writes=%0d required %h %b %0d 0",
                     rd, er, lat, wr_count, x_rd, x_er, x_lat);
        end
    endtask

    task automatic test_reset_abort;
        int seen;
        @(negedge i_clk);
        wr_count     = 0;
        i_req_valid  = 1'b1;
        i_req_we     = 1'b1;
        i_req_size   = 2'd2;
        i_req_signed = 1'b0;
        i_req_addr   = 32'h10;
        i_req_wdata  = 32'hDEADBEEF;
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        tests_run++;
        if (o_ram_action !== `RAM_WRITE || o_ram_val !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL abort_write_phase: action=%0d val=%h required RAM_WRITE DEADBEEF",
                     o_ram_action, o_ram_val);
        end
        #1;
        i_rst = 1'b1;
        #1;
        tests_run++;
        if (o_ram_action !== `RAM_READ || o_ram_addr !== 32'd0 || o_ram_val !== 32'd0 ||
            o_rsp_valid !== 1'b0 || o_err !== 1'b0 || o_rsp_rdata !== 32'd0 || o_req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_outputs: action=%0d addr=%h val=%h valid=%b err=%b rdata=%h ready=%b required reset values",
                     o_ram_action, o_ram_addr, o_ram_val, o_rsp_valid, o_err, o_rsp_rdata, o_req_ready);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        tests_run++;
        if (o_req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_ready: got %b required 1", o_req_ready);
        end
        seen = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge i_clk);
            if (o_rsp_valid) seen++;
        end
        tests_run++;
        if (seen != 0 || wr_count != 0 ||
            {ram[8'h10], ram[8'h11], ram[8'h12], ram[8'h13]} !== 32'h80123456) begin
            tests_failed++;
            $display("FAIL abort_no_commit: rsp=%0d writes=%0d mem=%h required 0 0 80123456",
                     seen, wr_count, {ram[8'h10], ram[8'h11], ram[8'h12], ram[8'h13]});
        end
    endtask

    task automatic test_error_then_load;
        logic [31:0] rd;
        logic        er, pok;
        int          lat;
        do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, rd, er, lat, pok);
        tests_run++;
        if (rd !== 32'd0 || er !== 1'b1 || lat != 1 || wr_count != 0 || !pok) begin
            tests_failed++;
            $display("FAIL size3_error: rdata=%h err=%b lat=%0d writes=%0d pulse=%b required 0 1 1 0 1",
                     rd, er, lat, wr_count, pok);
        end
        do_req(1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFFFFFF, rd, er, lat, pok);
        tests_run++;
        if (rd !== 32'd0 || er !== 1'b1 || lat != 1 || wr_count != 0) begin
            tests_failed++;
            $display("FAIL size3_store_error: rdata=%h err=%b lat=%0d writes=%0d required 0 1 1 0",
                     rd, er, lat, wr_count);
        end
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, pok);
        tests_run++;
        if (rd !== 32'h80123456 || er !== 1'b0 || lat != 2) begin
            tests_failed++;
            $display("FAIL load_after_error: rdata=%h err=%b lat=%0d required 80123456 0 2", rd, er, lat);
        end
    endtask

    task automatic test_byte_store;
        logic [31:0] rd, e_rd;
        logic        er, pok, e_er;
        int          lat, e_lat, e_wr;
        model_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AB, e_rd, e_er, e_lat, e_wr);
        do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AB, rd, er, lat, pok);
        tests_run++;
        if (wr_count != 1 || last_wval !== 32'hAB345600 || lat != 3 || er !== 1'b0 || rd !== 32'd0) begin
            tests_failed++;
            $display("FAIL byte_store: writes=%0d wval=%h lat=%0d err=%b rdata=%h required 1 AB345600 3 0 0",
                     wr_count, last_wval, lat, er, rd);
        end
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, pok);
        tests_run++;
        if (rd !== 32'h80AB3456 || er !== 1'b0 || lat != 2) begin
            tests_failed++;
            $display("FAIL load_after_store: rdata=%h err=%b lat=%0d required 80AB3456 0 2", rd, er, lat);
        end
    endtask

    task automatic test_random;
        logic        we, sgn, er, pok, e_er;
        logic [1:0]  size;
        logic [31:0] addr, wdata, rd, e_rd;
        int          lat, e_lat, e_wr, bad;
        for (int i = 0; i < 60; i++) begin
            we    = 1'($urandom_range(0, 1));
            sgn   = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 3));
            addr  = 32'h20 + 32'($urandom_range(0, 31));
            wdata = $urandom;
            model_req(we, size, sgn, addr, wdata, e_rd, e_er, e_lat, e_wr);
            do_req(we, size, sgn, addr, wdata, rd, er, lat, pok);
            tests_run++;
            if (rd !== e_rd || er !== e_er || lat != e_lat || wr_count != e_wr || !pok) begin
                tests_failed++;
                $display("FAIL random_%0d we=%b sz=%0d s=%b a=%h: rdata=%h err=%b lat=%0d writes=%0d pulse=%b required %h %b %0d %0d 1",
                         i, we, size, sgn, addr, rd, er, lat, wr_count, pok, e_rd, e_er, e_lat, e_wr);
            end
        end
        bad = 0;
        for (int a = 0; a < 256; a++)
            if (ram[a] !== ref_mem[a]) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL random_mem_image: %0d differing bytes required 0", bad);
        end
    endtask

    initial begin
        i_rst        = 1'b1;
        i_req_valid  = 1'b0;
        i_req_we     = 1'b0;
        i_req_size   = 2'd0;
        i_req_signed = 1'b0;
        i_req_addr   = 32'd0;
        i_req_wdata  = 32'd0;
        wr_count     = 0;
        last_wval    = 32'd0;
        for (int a = 0; a < 256; a++) begin
            ram[a]     = 8'($urandom);
            ref_mem[a] = ram[a];
        end
        ram[8'h10] = 8'h80; ram[8'h11] = 8'h12; ram[8'h12] = 8'h34; ram[8'h13] = 8'h56;
        ram[8'h14] = 8'h00;
        for (int a = 16; a < 21; a++) ref_mem[a] = ram[a];

        test_reset;
        test_loads;
        test_misaligned_half;
        test_reset_abort;
        test_error_then_load;
        test_byte_store;
        test_random;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
